fir_frame_sequencer: RTL and testbench

FIR_FRAME_SEQUENCER -- requirements
Module: fir_frame_sequencer

---
 rtl/fir_frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fir_frame_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_sequencer.sv
`timescale 1ns/1ps
// fir_frame_sequencer
//   Frames an upstream AXI4-Stream into a FIR filter slave port. A frame of
//   cfg_frame_len samples is passed straight through (zero latency). With
//   FIR_SEQ_FLUSH_EN defined, TAPS-1 zero samples then follow to drain the
//   filter history, and f_axis_last marks the final flush beat. Without the
//   macro, the frame ends on its last data beat, which carries f_axis_last.
//
// Ports
//   axi_clk, axi_reset_n        clock, async active-low reset
//   cfg_frame_len/start/abort   frame control (length latched on accepted start)
//   busy, done, cfg_err         status; done/cfg_err are one-cycle pulses
//   s_axis_*                    upstream AXI4-S slave
//   f_axis_*                    AXI4-S master into the FIR
//   frame_cnt                   completed frames since reset (wraps)
//
// Build option: FIR_SEQ_FLUSH_EN (enables the FLUSH state)
module fir_frame_sequencer #(
  parameter int unsigned DATA_INPUT = 16,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned TAPS       = 8
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic [LEN_W-1:0]      cfg_frame_len,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  s_axis_valid,
  input  logic [DATA_INPUT-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  f_axis_valid,
  output logic [DATA_INPUT-1:0] f_axis_data,
  output logic                  f_axis_last,
  input  logic                  f_axis_ready,
  output logic [LEN_W-1:0]      frame_cnt
);

  // A flush needs at least one zero beat.
  if (TAPS < 2) begin : g_taps_check
    $error("fir_frame_sequencer: TAPS must be at least 2");
  end

`ifdef FIR_SEQ_FLUSH_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;
  localparam int unsigned FL_W = $clog2(TAPS + 1);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(TAPS - 2);
  logic [FL_W-1:0] flush_q, flush_d;
`else
  typedef enum logic {S_IDLE, S_RUN} state_e;
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] frame_q, frame_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last_data;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
      flush_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef FIR_SEQ_FLUSH_EN
      flush_q <= flush_d;
`endif
    end
  end

  assign last_data = (beat_q == len_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    frame_d      = frame_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    s_axis_ready = 1'b0;
    f_axis_valid = 1'b0;
    f_axis_data  = '0;
    f_axis_last  = 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
    flush_d      = flush_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_frame_len != '0) begin
            len_d   = cfg_frame_len;
            beat_d  = '0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        f_axis_valid = s_axis_valid;
        f_axis_data  = s_axis_data;
        s_axis_ready = f_axis_ready;
        if (s_axis_valid && f_axis_ready) begin
          beat_d = beat_q + 1'b1;
        end
`ifdef FIR_SEQ_FLUSH_EN
        if ((s_axis_valid && f_axis_ready && last_data) || cfg_abort) begin
          state_d = S_FLUSH;
          flush_d = '0;
        end
`else
        f_axis_last = last_data;
        // A completing beat and an abort both end the frame with done;
        // only the completing beat carries last.
        if ((s_axis_valid && f_axis_ready && last_data) || cfg_abort) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          frame_d = frame_q + 1'b1;
        end
`endif
      end
`ifdef FIR_SEQ_FLUSH_EN
      S_FLUSH: begin
        // valid held high until every zero beat is taken
        f_axis_valid = 1'b1;
        f_axis_last  = (flush_q == FLUSH_LAST);
        if (f_axis_ready) begin
          if (flush_q == FLUSH_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            frame_d = frame_q + 1'b1;
          end else begin
            flush_d = flush_q + 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cfg_err   = err_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_fir_frame_sequencer.sv
`timescale 1ns/1ps
module tb_fir_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_len;
  logic        cfg_start, cfg_abort;
  logic        busy, done, cfg_err;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        f_valid, f_last, f_ready;
  logic [15:0] f_data;
  logic [15:0] frame_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_frames = 0;

  always #5 clk = ~clk;

  fir_frame_sequencer #(.DATA_INPUT(16), .LEN_W(16), .TAPS(8)) dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .cfg_frame_len(cfg_len),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .s_axis_valid (s_valid),
    .s_axis_data  (s_data),
    .s_axis_ready (s_ready),
    .f_axis_valid (f_valid),
    .f_axis_data  (f_data),
    .f_axis_last  (f_last),
    .f_axis_ready (f_ready),
    .frame_cnt    (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_frame(input logic [15:0] len);
    @(negedge clk);
    cfg_len   = len;
    cfg_start = 1'b1;
    s_valid   = 1'b0;
    f_ready   = 1'b1;
    #1;
    check("idle_busy",   32'(busy),    32'd0);
    check("idle_sready", 32'(s_ready), 32'd0);
    check("idle_fvalid", 32'(f_valid), 32'd0);
  endtask

  // Beat 1 also re-asserts cfg_start, which RUN must ignore.
  task automatic data_beats(input int unsigned len, input int unsigned nbeats,
                            input int unsigned abort_at);
    logic [15:0] exp_data;
    logic        exp_last;
    for (int unsigned i = 1; i <= nbeats; i++) begin
      @(negedge clk);
      exp_data  = 16'(i * 17 + 256);
      cfg_start = (i == 1);
      cfg_abort = (i == abort_at);
      s_valid   = 1'b1;
      s_data    = exp_data;
      f_ready   = 1'b1;
`ifdef FIR_SEQ_FLUSH_EN
      exp_last = 1'b0;
`else
      exp_last = (i == len);
`endif
      #1;
      check("run_fvalid", 32'(f_valid), 32'd1);
      check("run_fdata",  32'(f_data),  32'(exp_data));
      check("run_sready", 32'(s_ready), 32'd1);
      check("run_busy",   32'(busy),    32'd1);
      check("run_last",   32'(f_last),  32'(exp_last));
      check("run_err",    32'(cfg_err), 32'd0);
      check("run_done",   32'(done),    32'd0);
    end
  endtask

  task automatic finish_frame(input bit toggle);
    @(negedge clk);
    cfg_start = 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
    begin
      int unsigned beats = 0;
      int unsigned cyc   = 0;
      s_valid   = 1'b1;
      s_data    = 16'hBEEF;
      cfg_abort = 1'b1;  // abort in FLUSH must be ignored
      while (beats < 7 && cyc < 40) begin
        f_ready = toggle ? (cyc % 2 == 0) : 1'b1;
        #1;
        check("fl_fvalid", 32'(f_valid), 32'd1);
        check("fl_fdata",  32'(f_data),  32'd0);
        check("fl_sready", 32'(s_ready), 32'd0);
        check("fl_busy",   32'(busy),    32'd1);
        check("fl_last",   32'(f_last),  32'(beats == 6));
        check("fl_done",   32'(done),    32'd0);
        if (f_ready) beats++;
        cyc++;
        @(negedge clk);
      end
      check("fl_beats", beats, 32'd7);
    end
`endif
    s_valid   = 1'b0;
    cfg_abort = 1'b0;
    f_ready   = 1'b1;
    exp_frames++;
    #1;
    check("end_done",   32'(done),      32'd1);
    check("end_err",    32'(cfg_err),   32'd0);
    check("end_busy",   32'(busy),      32'd0);
    check("end_fvalid", 32'(f_valid),   32'd0);
    check("end_frames", 32'(frame_cnt), exp_frames);
    @(negedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_len = '0; cfg_start = 1'b0; cfg_abort = 1'b0;
    s_valid = 1'b0; s_data = '0; f_ready = 1'b1;
    #1;
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_err",    32'(cfg_err),   32'd0);
    check("rst_fvalid", 32'(f_valid),   32'd0);
    check("rst_last",   32'(f_last),    32'd0);
    check("rst_sready", 32'(s_ready),   32'd0);
    check("rst_frames", 32'(frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // zero-length start rejected
    start_frame(16'd0);
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    check("err_pulse",  32'(cfg_err), 32'd1);
    check("err_busy",   32'(busy),    32'd0);
    check("err_fvalid", 32'(f_valid), 32'd0);
    check("err_done",   32'(done),    32'd0);
    @(negedge clk);
    #1;
    check("err_once",   32'(cfg_err), 32'd0);
    check("err_busy2",  32'(busy),    32'd0);

`ifdef FIR_SEQ_FLUSH_EN
    start_frame(16'd4);  data_beats(4, 4, 0);  finish_frame(1'b0);
    start_frame(16'd10); data_beats(10, 3, 3); finish_frame(1'b0);
    start_frame(16'd2);  data_beats(2, 2, 0);  finish_frame(1'b1);
`else
    start_frame(16'd3);  data_beats(3, 3, 0);  finish_frame(1'b0);
    start_frame(16'd10); data_beats(10, 2, 2); finish_frame(1'b0);
    start_frame(16'd1);  data_beats(1, 1, 0);  finish_frame(1'b0);
`endif

    // reset in the middle of a frame
    start_frame(16'd5);
    data_beats(5, 2, 0);
    rst_n = 1'b0;
    exp_frames = 0;
    #1;
    check("mrst_fvalid", 32'(f_valid),   32'd0);
    check("mrst_sready", 32'(s_ready),   32'd0);
    check("mrst_busy",   32'(busy),      32'd0);
    check("mrst_last",   32'(f_last),    32'd0);
    check("mrst_frames", 32'(frame_cnt), exp_frames);
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("mrst_nodone", 32'(done), 32'd0);
      check("mrst_idle",   32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
